// File: rtl/prog_loader_if.sv
// Byte-stream input and instruction-ROM write bus of the boot-time program loader.
// The slave modport is the loader; the master modport is the byte source / ROM / core side.
interface prog_loader_if #(
  parameter int ADDR_W = 8
);
  logic              in_valid;
  logic [7:0]        in_data;
  logic              in_ready;
  logic              reload;
  logic              wr_en;
  logic [ADDR_W-1:0] wr_addr;
  logic [31:0]       wr_data;
  logic [15:0]       words_loaded;
  logic              cpu_run;
  logic              error;

  modport master (
    output in_valid, in_data, reload,
    input  in_ready, wr_en, wr_addr, wr_data, words_loaded, cpu_run, error
  );

  modport slave (
    input  in_valid, in_data, reload,
    output in_ready, wr_en, wr_addr, wr_data, words_loaded, cpu_run, error
  );
endinterface

// File: rtl/prog_loader.sv
// Parses a framed little-endian byte stream into 32-bit words for the LEGv8 instruction ROM,
// verifies the trailing 8-bit checksum and then releases the core via cpu_run.
module prog_loader #(
  parameter int DEPTH  = 256,
  parameter int ADDR_W = 8
) (
  input  logic         clock,
  input  logic         reset_n,
  prog_loader_if.slave bus
);

  typedef enum logic [2:0] {
    S_HDR0,
    S_HDR1,
    S_CHK_N,
    S_DATA,
    S_CSUM,
    S_RUN,
    S_ERR
  } state_e;

  state_e            state_q, state_d;
  logic [15:0]       n_q, n_d;
  logic [7:0]        sum_q, sum_d;
  logic [1:0]        bcnt_q, bcnt_d;
  logic [23:0]       asm_q, asm_d;
  logic              wr_en_q, wr_en_d;
  logic [ADDR_W-1:0] wr_addr_q, wr_addr_d;
  logic [31:0]       wr_data_q, wr_data_d;
  logic [15:0]       words_q, words_d;
  logic              live_q;
  logic              ready;
  logic              xfer;

  // live_q keeps in_ready low while reset is held and until the first edge after release.
  assign ready = live_q && (state_q inside {S_HDR0, S_HDR1, S_DATA, S_CSUM});
  assign xfer  = bus.in_valid && ready;

  always_ff @(posedge clock or negedge reset_n) begin
    if (!reset_n) begin
      state_q   <= S_HDR0;
      n_q       <= '0;
      sum_q     <= '0;
      bcnt_q    <= '0;
      asm_q     <= '0;
      wr_en_q   <= 1'b0;
      wr_addr_q <= '0;
      wr_data_q <= '0;
      words_q   <= '0;
      live_q    <= 1'b0;
    end else begin
      state_q   <= state_d;
      n_q       <= n_d;
      sum_q     <= sum_d;
      bcnt_q    <= bcnt_d;
      asm_q     <= asm_d;
      wr_en_q   <= wr_en_d;
      wr_addr_q <= wr_addr_d;
      wr_data_q <= wr_data_d;
      words_q   <= words_d;
      live_q    <= 1'b1;
    end
  end

  always_comb begin
    state_d   = state_q;
    n_d       = n_q;
    sum_d     = sum_q;
    bcnt_d    = bcnt_q;
    asm_d     = asm_q;
    wr_en_d   = 1'b0;
    wr_addr_d = wr_addr_q;
    wr_data_d = wr_data_q;
    words_d   = words_q;

    // reload beats any byte offered in the same cycle
    if (bus.reload) begin
      state_d = S_HDR0;
      n_d     = '0;
      sum_d   = '0;
      bcnt_d  = '0;
      words_d = '0;
    end else begin
      case (state_q)
        S_HDR0: begin
          if (xfer) begin
            n_d[7:0] = bus.in_data;
            sum_d    = sum_q + bus.in_data;
            state_d  = S_HDR1;
          end
        end
        S_HDR1: begin
          if (xfer) begin
            n_d[15:8] = bus.in_data;
            sum_d     = sum_q + bus.in_data;
            state_d   = S_CHK_N;
          end
        end
        S_CHK_N: begin
          bcnt_d = '0;
          if (n_q > 16'(DEPTH)) begin
            state_d = S_ERR;
          end else if (n_q == 16'd0) begin
            state_d = S_CSUM;
          end else begin
            state_d = S_DATA;
          end
        end
        S_DATA: begin
          if (xfer) begin
            sum_d  = sum_q + bus.in_data;
            bcnt_d = bcnt_q + 2'd1;
            if (bcnt_q == 2'd3) begin
              // Bytes arrive LSB first, so the final byte lands on top of the word.
              wr_en_d   = 1'b1;
              wr_data_d = {bus.in_data, asm_q};
              wr_addr_d = words_q[ADDR_W-1:0];
              words_d   = words_q + 16'd1;
              if (words_q + 16'd1 == n_q) begin
                state_d = S_CSUM;
              end
            end else begin
              asm_d = {bus.in_data, asm_q[23:8]};
            end
          end
        end
        S_CSUM: begin
          if (xfer) begin
            state_d = (bus.in_data == sum_q) ? S_RUN : S_ERR;
          end
        end
        S_RUN:   state_d = S_RUN;
        S_ERR:   state_d = S_ERR;
        default: state_d = S_HDR0;
      endcase
    end
  end

  assign bus.in_ready     = ready;
  assign bus.wr_en        = wr_en_q;
  assign bus.wr_addr      = wr_addr_q;
  assign bus.wr_data      = wr_data_q;
  assign bus.words_loaded = words_q;
  assign bus.cpu_run      = (state_q == S_RUN);
  assign bus.error        = (state_q == S_ERR);

endmodule

// File: tb/tb_prog_loader.sv
// Randomised and directed frames checked against a frame-level reference model of the loader.
module tb_prog_loader;
  localparam int DEPTH  = 256;
  localparam int ADDR_W = 8;

  logic clock   = 1'b0;
  logic reset_n = 1'b0;
  always #5 clock = ~clock;

  prog_loader_if #(.ADDR_W(ADDR_W)) bus ();

  prog_loader #(.DEPTH(DEPTH), .ADDR_W(ADDR_W)) dut (
    .clock   (clock),
    .reset_n (reset_n),
    .bus     (bus)
  );

  int total = 0;
  int bad   = 0;

  logic [39:0] wq[$];
  logic [39:0] exp_wq[$];
  logic [7:0]  fq[$];
  logic        exp_run;
  logic        exp_err;
  logic [15:0] exp_words;

  logic [7:0] norm [11] = '{8'h02, 8'h00, 8'h20, 8'h00, 8'h02, 8'h8B,
                            8'h41, 8'h00, 8'h40, 8'hF8, 8'h28};

  // Record every ROM write seen on the bus.
  always @(negedge clock) begin
    if (reset_n && bus.wr_en === 1'b1) wq.push_back({bus.wr_addr, bus.wr_data});
  end

  task automatic check(input string tag, input logic [63:0] obs, input logic [63:0] exp);
    total++;
    assert (obs === exp) else begin
      bad++;
      $error("FAIL %s observed=%0h expected=%0h", tag, obs, exp);
    end
  endtask

  task automatic tick();
    @(posedge clock);
    #1;
  endtask

  task automatic send_byte(input logic [7:0] b, input int max_gap);
    int w;
    w = 0;
    if (max_gap > 0) repeat ($urandom_range(max_gap, 0)) tick();
    bus.in_valid = 1'b1;
    bus.in_data  = b;
    while (bus.in_ready !== 1'b1 && w < 40) begin
      tick();
      w++;
    end
    if (w >= 40) check("ready_wait_bound", 64'(w), 64'd0);
    else tick();
    bus.in_valid = 1'b0;
  endtask

  task automatic pulse_reload();
    bus.reload = 1'b1;
    tick();
    bus.reload = 1'b0;
  endtask

  // Reference: what a loader must do with a whole frame, from the frame rules alone.
  task automatic model();
    int n;
    logic [7:0] s;
    exp_wq.delete();
    n = {fq[1], fq[0]};
    exp_words = 16'd0;
    if (n > DEPTH) begin
      exp_err = 1'b1;
      exp_run = 1'b0;
    end else begin
      for (int k = 0; k < n; k++)
        exp_wq.push_back({8'(k), fq[2+4*k+3], fq[2+4*k+2], fq[2+4*k+1], fq[2+4*k]});
      exp_words = 16'(n);
      s = 8'd0;
      for (int i = 0; i < 2 + 4 * n; i++) s = s + fq[i];
      exp_run = (fq[2+4*n] == s);
      exp_err = !exp_run;
    end
  endtask

  task automatic make_frame(input int n, input bit corrupt);
    logic [7:0] s;
    logic [7:0] b;
    fq.delete();
    fq.push_back(8'(n));
    fq.push_back(8'(n >> 8));
    s = 8'(n) + 8'(n >> 8);
    for (int i = 0; i < 4 * n; i++) begin
      b = 8'($urandom);
      fq.push_back(b);
      s = s + b;
    end
    fq.push_back(corrupt ? s + 8'd1 : s);
  endtask

  task automatic run_frame(input bit do_reload, input int max_gap, input string tag);
    int n;
    int nsend;
    if (do_reload) pulse_reload();
    wq.delete();
    model();
    n = {fq[1], fq[0]};
    nsend = (n > DEPTH) ? 2 : fq.size();
    for (int i = 0; i < nsend; i++) send_byte(fq[i], max_gap);
    if (n <= DEPTH) begin
      check({tag, ".run_edge"}, 64'(bus.cpu_run), 64'(exp_run));
      check({tag, ".err_edge"}, 64'(bus.error), 64'(exp_err));
    end
    repeat (2) tick();
    check({tag, ".nwrites"}, 64'(wq.size()), 64'(exp_wq.size()));
    for (int i = 0; i < exp_wq.size() && i < wq.size(); i++)
      check({tag, ".write"}, 64'(wq[i]), 64'(exp_wq[i]));
    check({tag, ".words"}, 64'(bus.words_loaded), 64'(exp_words));
    check({tag, ".run"}, 64'(bus.cpu_run), 64'(exp_run));
    check({tag, ".err"}, 64'(bus.error), 64'(exp_err));
    check({tag, ".ready"}, 64'(bus.in_ready), 64'd0);
    $display("frame %s: N=%0d writes=%0d run=%0b err=%0b", tag, n, wq.size(), bus.cpu_run, bus.error);
  endtask

  initial begin
    #500000;
    $display("FAIL watchdog: simulation time limit reached");
    $fatal(1, "watchdog");
  end

  initial begin
    logic [7:0] last_addr;
    bus.in_valid = 1'b0;
    bus.in_data  = 8'h00;
    bus.reload   = 1'b0;

    // Reset state
    repeat (2) tick();
    check("rst.wr_en", 64'(bus.wr_en), 64'd0);
    check("rst.wr_addr", 64'(bus.wr_addr), 64'd0);
    check("rst.wr_data", 64'(bus.wr_data), 64'd0);
    check("rst.words", 64'(bus.words_loaded), 64'd0);
    check("rst.run", 64'(bus.cpu_run), 64'd0);
    check("rst.err", 64'(bus.error), 64'd0);
    check("rst.ready_held", 64'(bus.in_ready), 64'd0);
    reset_n = 1'b1;
    tick();
    check("rst.ready_up", 64'(bus.in_ready), 64'd1);

    // Normal load with cycle-exact write checks
    fq.delete();
    for (int i = 0; i < 11; i++) fq.push_back(norm[i]);
    wq.delete();
    for (int i = 0; i < 6; i++) send_byte(fq[i], 0);
    check("norm.w0_en", 64'(bus.wr_en), 64'd1);
    check("norm.w0_addr", 64'(bus.wr_addr), 64'd0);
    check("norm.w0_data", 64'(bus.wr_data), 64'h8B020020);
    check("norm.w0_words", 64'(bus.words_loaded), 64'd1);
    for (int i = 6; i < 9; i++) send_byte(fq[i], 0);
    check("norm.en_low", 64'(bus.wr_en), 64'd0);
    check("norm.addr_hold", 64'(bus.wr_addr), 64'd0);
    send_byte(fq[9], 0);
    check("norm.w1_en", 64'(bus.wr_en), 64'd1);
    check("norm.w1_addr", 64'(bus.wr_addr), 64'd1);
    check("norm.w1_data", 64'(bus.wr_data), 64'hF8400041);
    check("norm.run_before", 64'(bus.cpu_run), 64'd0);
    send_byte(fq[10], 0);
    check("norm.run_after", 64'(bus.cpu_run), 64'd1);
    check("norm.err", 64'(bus.error), 64'd0);
    check("norm.words", 64'(bus.words_loaded), 64'd2);
    check("norm.nwrites", 64'(wq.size()), 64'd2);
    $display("frame normal: writes=%0d run=%0b", wq.size(), bus.cpu_run);

    // Same frame with random in_valid gaps
    run_frame(1'b1, 3, "gap");

    // Checksum mismatch
    fq[10] = 8'h29;
    run_frame(1'b1, 0, "mism");
    check("mism.nwrites_const", 64'(wq.size()), 64'd2);
    check("mism.err_const", 64'(bus.error), 64'd1);

    // Empty program
    fq.delete();
    repeat (3) fq.push_back(8'h00);
    run_frame(1'b1, 0, "empty");
    check("empty.run_const", 64'(bus.cpu_run), 64'd1);

    // Oversize program: error appears two cycles after the hi byte
    pulse_reload();
    wq.delete();
    send_byte(8'h01, 0);
    send_byte(8'h01, 0);
    check("over.chk_ready", 64'(bus.in_ready), 64'd0);
    check("over.chk_err", 64'(bus.error), 64'd0);
    tick();
    check("over.err", 64'(bus.error), 64'd1);
    check("over.run", 64'(bus.cpu_run), 64'd0);
    repeat (3) tick();
    check("over.nwrites", 64'(wq.size()), 64'd0);
    $display("frame oversize: writes=%0d err=%0b", wq.size(), bus.error);

    // N == DEPTH boundary
    make_frame(DEPTH, 1'b0);
    run_frame(1'b1, 1, "full");
    last_addr = (wq.size() != 0) ? wq[wq.size()-1][39:32] : 8'hxx;
    check("full.last_addr", 64'(last_addr), 64'd255);

    // Random frames
    for (int t = 0; t < 6; t++) begin
      make_frame(int'($urandom_range(8, 1)), 1'($urandom_range(1, 0)));
      run_frame(1'b1, 3, "rnd");
    end

    // Reset mid-load: one full word then two bytes of the next
    make_frame(3, 1'b0);
    pulse_reload();
    for (int i = 0; i < 8; i++) send_byte(fq[i], 0);
    check("mid.words_pre", 64'(bus.words_loaded), 64'd1);
    reset_n = 1'b0;
    #1;
    check("mid.wr_addr", 64'(bus.wr_addr), 64'd0);
    check("mid.wr_data", 64'(bus.wr_data), 64'd0);
    check("mid.words", 64'(bus.words_loaded), 64'd0);
    check("mid.ready", 64'(bus.in_ready), 64'd0);
    tick();
    reset_n = 1'b1;
    tick();
    make_frame(2, 1'b0);
    run_frame(1'b0, 2, "post_rst");

    // Reload in RUN with a simultaneous byte that must be dropped
    check("rl.run_pre", 64'(bus.cpu_run), 64'd1);
    bus.reload   = 1'b1;
    bus.in_valid = 1'b1;
    bus.in_data  = 8'h05;
    tick();
    bus.reload   = 1'b0;
    bus.in_valid = 1'b0;
    check("rl.run", 64'(bus.cpu_run), 64'd0);
    check("rl.err", 64'(bus.error), 64'd0);
    check("rl.words", 64'(bus.words_loaded), 64'd0);
    check("rl.ready", 64'(bus.in_ready), 64'd1);
    make_frame(1, 1'b0);
    run_frame(1'b0, 0, "after_rl");

    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end
endmodule

// File: doc/prog_loader.md
# prog_loader

Boot-time program loader that sits directly upstream of the single-cycle LEGv8 core's instruction ROM. It accepts a framed byte stream over a valid/ready handshake and assembles little-endian 32-bit instruction words. It writes each word into the ROM's write port, verifies an 8-bit checksum, and only then releases the core via `cpu_run`. The core's `clock` is gated or held in reset externally by `cpu_run`.

## Interface
- `DEPTH`, 256: instruction ROM capacity in 32-bit words.
- `ADDR_W`, 8: width of `wr_addr`; must satisfy 2^ADDR_W >= DEPTH.
- `clock`  in  1  single system clock; all state updates on rising edge.
- `reset_n`  in  1  asynchronous, active-low reset.
- `in_valid`  in  1  byte on `in_data` is valid.
- `in_data`  in  8  stream byte.
- `in_ready`  out  1  loader can accept a byte this cycle.
- `reload`  in  1  single-cycle pulse; aborts or finishes and restarts framing.
- `wr_en`  out  1  ROM write strobe, one cycle per word.
- `wr_addr`  out  ADDR_W  ROM word index; byte address seen by PC = wr_addr*4.
- `wr_data`  out  32  assembled instruction word.
- `words_loaded`  out  16  words written in current load.
- `cpu_run`  out  1  program loaded and verified; core may execute.
- `error`  out  1  load failed; sticky until reset or `reload`.

## Operation
- Frame: `N` lo byte, `N` hi byte, then N×4 data bytes (each word LSB first), then checksum byte.
- Checksum byte must equal the sum mod 256 of all preceding frame bytes, header included.
- A byte transfers on a rising edge with `in_valid && in_ready`.
- States:
  - HDR0: capture N[7:0] → HDR1.
  - HDR1: capture N[15:8] → CHK_N.
  - CHK_N (1 cycle, `in_ready`=0): N > DEPTH → ERR. N == 0 → CSUM. Otherwise → DATA.
  - DATA: shift bytes into a 32-bit assembly register with a 2-bit byte counter. On the 4th byte the word is registered onto `wr_data`/`wr_addr` and `wr_en` is pulsed; `words_loaded` increments with the write. After the word where `words_loaded` reaches N → CSUM.
  - CSUM: compare the accepted byte with the running sum. Match → RUN. Mismatch → ERR.
  - RUN: `cpu_run`=1, `in_ready`=0.
  - ERR: `error`=1, `in_ready`=0.
- `in_ready`=1 only in HDR0, HDR1, DATA, CSUM.
- Running sum: 8-bit, wraps silently; cleared on entry to HDR0.
- `reload` in any state → HDR0 next cycle. It clears N, the sum, the byte counter, `words_loaded`, `cpu_run` and `error`. A byte transferred in the same cycle is discarded (`reload` wins).
- ROM contents are never erased. Reload or reset simply overwrites from index 0.

## Timing
- Reset values: state HDR0, `wr_en`=0, `wr_addr`=0, `wr_data`=0, `words_loaded`=0, `cpu_run`=0, `error`=0.
- `in_ready`=1 from the first edge after `reset_n` deasserts.
- `wr_en` is high exactly the cycle after the 4th byte of a word transfers. `wr_addr` and `wr_data` are valid in that same cycle.
- `wr_addr` holds its value between writes, then advances by 1 after each write.
- `cpu_run` rises the cycle after a matching checksum byte transfers.
- `error` rises one cycle after the checksum mismatch, or one cycle after CHK_N for oversize N.
- Back-to-back bytes every cycle are sustained. Gaps in `in_valid` stall without state change.
- `reset_n` low mid-load: all outputs go to reset values immediately (asynchronous). A partially assembled word is dropped and never written.
- `DEPTH` boundary: N == DEPTH is legal; the last write goes to `wr_addr` = DEPTH-1.

## Test plan
- Normal load:
  - Stimulus: bytes 02 00 | 20 00 02 8B | 41 00 40 F8 | 28.
  - Required: writes (0, 0x8B020020) then (1, 0xF8400041); `words_loaded`=2; `cpu_run`=1 one cycle after 0x28; `error`=0.
- Checksum mismatch:
  - Stimulus: same frame, final byte 0x29.
  - Required: both writes still occur; `error`=1, `cpu_run`=0, `in_ready`=0.
- Empty program:
  - Stimulus: 00 00 00.
  - Required: no `wr_en`; `cpu_run`=1.
- Oversize program:
  - Stimulus: N=257 (01 01) with DEPTH=256.
  - Required: `error`=1 two cycles after the hi byte; no `wr_en`. Also N=256: the last write is at `wr_addr`=255.
- Stall, then reset mid-load:
  - Stimulus: random `in_valid` gaps yield identical writes. Then assert `reset_n`=0 after 2 data bytes.
  - Required: outputs clear immediately. A new frame writes from `wr_addr`=0 with correct words.
- Reload:
  - Stimulus: pulse `reload` in RUN, coinciding with `in_valid`=1 and byte 0x05.
  - Required: `cpu_run`=0 next cycle; the byte is ignored; the next frame parses from HDR0.
